// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate enable, horizontal/vertical counters,
// sync/visible decode and registered line/frame ticks.
module vga_sync_gen #(
   parameter int CLK_DIV = 4,
   parameter int HPIXELS = 800,
   parameter int VLINES  = 525,
   parameter int HSP     = 128,
   parameter int VSP     = 2,
   parameter int HBP     = 144,
   parameter int HFP     = 784,
   parameter int VBP     = 31,
   parameter int VFP     = 511
) (
   input  logic       clk,
   input  logic       clr,
   output logic       pix_en,
   output logic [9:0] hc,
   output logic [9:0] vc,
   output logic       hsync,
   output logic       vsync,
   output logic       vidon,
   output logic       line_tick,
   output logic       frame_tick
);

   localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0]  H_LAST   = 10'(HPIXELS - 1);
   localparam logic [9:0]  V_LAST   = 10'(VLINES - 1);
   // 11-bit thresholds so a front porch of exactly 1024 still compares correctly
   localparam logic [10:0] HSP_C    = 11'(HSP);
   localparam logic [10:0] VSP_C    = 11'(VSP);
   localparam logic [10:0] HBP_C    = 11'(HBP);
   localparam logic [10:0] HFP_C    = 11'(HFP);
   localparam logic [10:0] VBP_C    = 11'(VBP);
   localparam logic [10:0] VFP_C    = 11'(VFP);

   logic [3:0] div_q, div_d;
   logic       pix_en_q, pix_en_d;
   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       line_tick_q, line_tick_d;
   logic       frame_tick_q, frame_tick_d;

   always_comb begin
      div_d        = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
      pix_en_d     = (div_q == DIV_LAST);
      hc_d         = hc_q;
      vc_d         = vc_q;
      line_tick_d  = 1'b0;
      frame_tick_d = 1'b0;
      if (pix_en_q) begin
         if (hc_q == H_LAST) begin
            hc_d        = 10'd0;
            line_tick_d = 1'b1;
            if (vc_q == V_LAST) begin
               vc_d         = 10'd0;
               frame_tick_d = 1'b1;
            end else begin
               vc_d = vc_q + 10'd1;
            end
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         div_q        <= 4'd0;
         pix_en_q     <= 1'b0;
         hc_q         <= 10'd0;
         vc_q         <= 10'd0;
         line_tick_q  <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         pix_en_q     <= pix_en_d;
         hc_q         <= hc_d;
         vc_q         <= vc_d;
         line_tick_q  <= line_tick_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign pix_en     = pix_en_q;
   assign hc         = hc_q;
   assign vc         = vc_q;
   assign line_tick  = line_tick_q;
   assign frame_tick = frame_tick_q;

   // Decode straight off the registered counters: zero latency relative to hc/vc
   assign hsync = ({1'b0, hc_q} >= HSP_C);
   assign vsync = ({1'b0, vc_q} >= VSP_C);
   assign vidon = ({1'b0, hc_q} >= HBP_C) && ({1'b0, hc_q} < HFP_C) &&
                  ({1'b0, vc_q} >= VBP_C) && ({1'b0, vc_q} < VFP_C);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three geometries checked cycle-by-cycle against a
// closed-form raster model through per-instance expectation queues.
module tb_vga_sync_gen;

   // u0: default timing; u1: default geometry, divide-by-1; u2: tiny raster for frame behaviour
   localparam int D2 = 2, H2 = 20, V2 = 12;
   localparam int HSP2 = 3, VSP2 = 2, HBP2 = 5, HFP2 = 17, VBP2 = 4, VFP2 = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clr0, clr1, clr2;
   logic       pe0, hs0, vs0, vo0, lt0, ft0;
   logic       pe1, hs1, vs1, vo1, lt1, ft1;
   logic       pe2, hs2, vs2, vo2, lt2, ft2;
   logic [9:0] hc0, vc0, hc1, vc1, hc2, vc2;

   vga_sync_gen u0 (
      .clk(clk), .clr(clr0), .pix_en(pe0), .hc(hc0), .vc(vc0), .hsync(hs0),
      .vsync(vs0), .vidon(vo0), .line_tick(lt0), .frame_tick(ft0)
   );

   vga_sync_gen #(.CLK_DIV(1)) u1 (
      .clk(clk), .clr(clr1), .pix_en(pe1), .hc(hc1), .vc(vc1), .hsync(hs1),
      .vsync(vs1), .vidon(vo1), .line_tick(lt1), .frame_tick(ft1)
   );

   vga_sync_gen #(
      .CLK_DIV(D2), .HPIXELS(H2), .VLINES(V2), .HSP(HSP2), .VSP(VSP2),
      .HBP(HBP2), .HFP(HFP2), .VBP(VBP2), .VFP(VFP2)
   ) u2 (
      .clk(clk), .clr(clr2), .pix_en(pe2), .hc(hc2), .vc(vc2), .hsync(hs2),
      .vsync(vs2), .vidon(vo2), .line_tick(lt2), .frame_tick(ft2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // n = clk edges since reset release (0 = in reset). Pixel index p advances
   // one edge after each pix_en pulse; ticks appear when p lands on a wrap.
   // Packing: {pix_en, line_tick, frame_tick, hsync, vsync, vidon, hc, vc}
   function automatic logic [25:0] model(input int n, input int d, input int h, input int v,
                                         input int hsp, input int vsp, input int hbp,
                                         input int hfp, input int vbp, input int vfp);
      int   p, x, y;
      logic pe, adv, lt, ft, hs, vs, vo;
      p   = (n == 0) ? 0 : (n - 1) / d;
      x   = p % h;
      y   = (p / h) % v;
      pe  = (n >= 1) && (n % d == 0);
      adv = (n >= 2) && ((n - 1) % d == 0);
      lt  = adv && (x == 0);
      ft  = lt && (y == 0);
      hs  = (x >= hsp);
      vs  = (y >= vsp);
      vo  = (x >= hbp) && (x < hfp) && (y >= vbp) && (y < vfp);
      return {pe, lt, ft, hs, vs, vo, 10'(x), 10'(y)};
   endfunction

   int n0 = 0, n1 = 0, n2 = 0;
   logic [25:0] q0[$], q1[$], q2[$];

   always @(posedge clk) begin
      n0 = clr0 ? n0 + 1 : 0;
      n1 = clr1 ? n1 + 1 : 0;
      n2 = clr2 ? n2 + 1 : 0;
      q0.push_back(model(n0, 4, 800, 525, 128, 2, 144, 784, 31, 511));
      q1.push_back(model(n1, 1, 800, 525, 128, 2, 144, 784, 31, 511));
      q2.push_back(model(n2, D2, H2, V2, HSP2, VSP2, HBP2, HFP2, VBP2, VFP2));
   end

   int cyc = 0;
   int last_lt1 = -1, last_ft2 = -1;
   int n_lt_per1 = 0, n_ft_per2 = 0, n_lt0 = 0, n_vsync_low2 = 0;

   always @(negedge clk) begin
      cyc++;
      if (q0.size() > 0) chk("u0_raster", {pe0, lt0, ft0, hs0, vs0, vo0, hc0, vc0}, q0.pop_front());
      if (q1.size() > 0) chk("u1_raster", {pe1, lt1, ft1, hs1, vs1, vo1, hc1, vc1}, q1.pop_front());
      if (q2.size() > 0) chk("u2_raster", {pe2, lt2, ft2, hs2, vs2, vo2, hc2, vc2}, q2.pop_front());
      if (n0 != 0 && lt0) n_lt0++;
      if (n1 == 0) last_lt1 = -1;
      else if (lt1) begin
         if (last_lt1 >= 0) begin
            chk("u1_line_period", cyc - last_lt1, 800);
            n_lt_per1++;
         end
         last_lt1 = cyc;
      end
      if (n2 == 0) last_ft2 = -1;
      else if (ft2) begin
         if (last_ft2 >= 0) begin
            chk("u2_frame_period", cyc - last_ft2, D2 * H2 * V2);
            n_ft_per2++;
         end
         last_ft2 = cyc;
      end
      if (n2 != 0 && !vs2) n_vsync_low2++;
   end

   initial begin
      clr0 = 1'b0;
      clr1 = 1'b0;
      clr2 = 1'b0;
      repeat (3) @(negedge clk);
      clr0 = 1'b1;
      clr1 = 1'b1;
      clr2 = 1'b1;
      // u0 is pulsed into reset at (hc,vc)=(400,1); u2 mid-frame at (10,1)
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         clr0 = (k != 4800);
         clr2 = (k != 1500);
      end
      @(negedge clk);
      #1;
      chk("u0_line_ticks_seen", n_lt0, 1);
      chk("u1_line_periods_seen", (n_lt_per1 > 0), 1);
      chk("u2_frame_periods_seen", (n_ft_per2 > 0), 1);
      chk("u2_vsync_low_nonzero", (n_vsync_low2 > 0), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
